// File: rtl/xbus_pkg.sv
// Shared definitions for the xbus address decoder: FSM states and default slave windows.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package xbus_pkg;

  // Geometry of the default window table.
  localparam int XB_ADDR_W = 16;
  localparam int XB_N_SLV  = 4;

  // xdefs window constants: memory, register file, two peripheral blocks.
  localparam logic [XB_ADDR_W-1:0] XDEF_MEM_BASE  = 16'h0000;
  localparam logic [XB_ADDR_W-1:0] XDEF_MEM_MASK  = 16'hF800;
  localparam logic [XB_ADDR_W-1:0] XDEF_RF_BASE   = 16'h0800;
  localparam logic [XB_ADDR_W-1:0] XDEF_RF_MASK   = 16'hFFF0;
  localparam logic [XB_ADDR_W-1:0] XDEF_PER0_BASE = 16'h0810;
  localparam logic [XB_ADDR_W-1:0] XDEF_PER0_MASK = 16'hFFFC;
  localparam logic [XB_ADDR_W-1:0] XDEF_PER1_BASE = 16'h0814;
  localparam logic [XB_ADDR_W-1:0] XDEF_PER1_MASK = 16'hFFFC;

  // Transaction FSM: accept, wait for the selected slave, one-cycle response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } xbus_state_e;

  // Packs the xdefs windows into the flattened layout (slave i at bits [i*ADDR_W +: ADDR_W]).
  function automatic logic [XB_N_SLV*XB_ADDR_W-1:0] xbus_default_vec(input logic is_mask);
    if (is_mask) begin
      return {XDEF_PER1_MASK, XDEF_PER0_MASK, XDEF_RF_MASK, XDEF_MEM_MASK};
    end
    return {XDEF_PER1_BASE, XDEF_PER0_BASE, XDEF_RF_BASE, XDEF_MEM_BASE};
  endfunction

  localparam logic [XB_N_SLV*XB_ADDR_W-1:0] XB_DEFAULT_BASE_VEC = xbus_default_vec(1'b0);
  localparam logic [XB_N_SLV*XB_ADDR_W-1:0] XB_DEFAULT_MASK_VEC = xbus_default_vec(1'b1);

  // Width of a slave index; a single slave still needs one bit.
  function automatic int xbus_idx_width(input int n_slv);
    return (n_slv > 1) ? $clog2(n_slv) : 1;
  endfunction

  // Width of the wait counter; it only ever reaches TIMEOUT-1, so TIMEOUT+1 states is ample.
  function automatic int xbus_cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/xbus_match.sv
// Priority address matcher: compares an address against N_SLV base/mask windows.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows addr_i every cycle.
module xbus_match
  import xbus_pkg::*;
#(
  parameter int                          ADDR_W   = XB_ADDR_W,
  parameter int                          N_SLV    = XB_N_SLV,
  parameter logic [N_SLV*ADDR_W-1:0]     BASE_VEC = XB_DEFAULT_BASE_VEC,
  parameter logic [N_SLV*ADDR_W-1:0]     MASK_VEC = XB_DEFAULT_MASK_VEC,
  parameter int                          IDX_W    = xbus_idx_width(N_SLV)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scan from the highest index down so the lowest matching window is written last and wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr_i & MASK_VEC[i*ADDR_W +: ADDR_W]) == BASE_VEC[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/xbus_decoder.sv
// Registered master-to-slave decoder: one-hot slave select, waits for ready, returns data or error.
// Latency: hit with ready slave acks 2 cycles after m_req; miss acks after 1; timeout after TIMEOUT+1.
// Backpressure: busy is high outside IDLE; any m_req while busy is dropped, slaves stall via s_ready.
module xbus_decoder
  import xbus_pkg::*;
#(
  parameter int                      ADDR_W   = 16,
  parameter int                      DATA_W   = 32,
  parameter int                      N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0] BASE_VEC = XB_DEFAULT_BASE_VEC,
  parameter logic [N_SLV*ADDR_W-1:0] MASK_VEC = XB_DEFAULT_MASK_VEC,
  parameter int                      TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m_req,
  input  logic [ADDR_W-1:0]       m_addr,
  output logic                    busy,
  output logic                    m_ack,
  output logic                    m_err,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [N_SLV-1:0]        s_sel,
  input  logic [N_SLV-1:0]        s_ready,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
  output logic                    trap_sel
);

  localparam int IDX_W = xbus_idx_width(N_SLV);
  localparam int CNT_W = xbus_cnt_width(TIMEOUT);
  // A zero TIMEOUT means wait forever.
  localparam bit TO_EN = (TIMEOUT != 0);
  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Registered state
  xbus_state_e        state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_SLV-1:0]   sel_q;
  logic               ack_q;
  logic               err_q;
  logic               trap_q;
  logic [DATA_W-1:0]  rdata_q;

  // Matcher results and selected-slave view
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [N_SLV-1:0]   hit_onehot;
  logic               slv_ready;
  logic [DATA_W-1:0]  slv_rdata;

  xbus_match #(
    .ADDR_W   (ADDR_W),
    .N_SLV    (N_SLV),
    .BASE_VEC (BASE_VEC),
    .MASK_VEC (MASK_VEC),
    .IDX_W    (IDX_W)
  ) u_match (
    .addr_i (m_addr),
    .hit_o  (hit),
    .idx_o  (hit_idx)
  );

  // One-hot select for the winning window of the current request.
  always_comb begin
    hit_onehot = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (hit_idx == IDX_W'(i)) begin
        hit_onehot[i] = 1'b1;
      end
    end
  end

  // Only the latched slave's ready and data are visible to the FSM; the others are ignored.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slv_ready = s_ready[i];
        slv_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with registered select and response outputs; ack/err/trap pulse only in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      trap_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      trap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m_req) begin
            if (hit) begin
              idx_q   <= hit_idx;
              sel_q   <= hit_onehot;
              cnt_q   <= '0;
              state_q <= WAIT;
            end else begin
              // Unmapped address: respond with an error straight away, no slave touched.
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              trap_q  <= 1'b1;
              rdata_q <= '0;
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          if (slv_ready) begin
            // Ready is checked first so it wins over a coincident timeout.
            sel_q   <= '0;
            ack_q   <= 1'b1;
            rdata_q <= slv_rdata;
            state_q <= RESP;
          end else if (TO_EN && (cnt_q == CNT_LAST)) begin
            sel_q   <= '0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            trap_q  <= 1'b1;
            rdata_q <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          sel_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign s_sel    = sel_q;
  assign m_ack    = ack_q;
  assign m_err    = err_q;
  assign m_rdata  = rdata_q;
  assign trap_sel = trap_q;

endmodule

// File: tb/tb_xbus_decoder.sv
// Scoreboard bench for xbus_decoder: directed requests push expected responses, a monitor pops on m_ack.
// Latency: checks cycle-exact select/ack timing for hit, miss, timeout and ready-wins cases.
// Backpressure: exercises dropped requests while busy and asynchronous reset mid-transaction.
module tb_xbus_decoder;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int N_SLV   = 4;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic                    clk;
  logic                    rst_n;
  logic                    m_req;
  logic [ADDR_W-1:0]       m_addr;
  logic                    busy;
  logic                    m_ack;
  logic                    m_err;
  logic [DATA_W-1:0]       m_rdata;
  logic [N_SLV-1:0]        s_sel;
  logic [N_SLV-1:0]        s_ready;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic                    trap_sel;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;
  int   n_ack;

  xbus_decoder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_SLV    (N_SLV),
    .BASE_VEC (64'h0814_0810_0800_0000),
    .MASK_VEC (64'hFFFC_FFFC_FFF0_F800),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .busy     (busy),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s_sel    (s_sel),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .trap_sel (trap_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [DATA_W-1:0] rdata);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    return e;
  endfunction

  // Drives a one-cycle request; returns just after the edge that sampled it (start of cycle 1).
  task automatic issue(input logic [ADDR_W-1:0] addr);
    @(posedge clk);
    #1;
    m_req  = 1'b1;
    m_addr = addr;
    @(posedge clk);
    #1;
    m_req  = 1'b0;
  endtask

  // Bounded wait for the DUT to return to IDLE with every expected response consumed.
  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 64'(ok), 64'(1'b1));
  endtask

  // Monitor: every ack is matched against the oldest expected response; flags are quiet otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_ack) begin
        n_ack++;
        chk("ack_expected", 64'(exp_q.size() > 0), 64'(1'b1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ack_err",   64'(m_err),    64'(e.err));
          chk("ack_rdata", 64'(m_rdata),  64'(e.rdata));
          chk("ack_trap",  64'(trap_sel), 64'(e.err));
        end
      end else begin
        chk("quiet_err_trap", 64'({m_err, trap_sel}), 64'(2'b00));
      end
    end
  end

  // Absolute time bound so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus and cycle-exact checks.
  initial begin
    int bad;
    int ack_base;
    n_chk   = 0;
    n_fail  = 0;
    n_ack   = 0;
    rst_n   = 1'b0;
    m_req   = 1'b0;
    m_addr  = '0;
    s_ready = '0;
    s_rdata = '0;

    // Reset state
    #12;
    chk("rst_sel",   64'(s_sel),    64'(4'b0000));
    chk("rst_busy",  64'(busy),     64'(1'b0));
    chk("rst_ack",   64'(m_ack),    64'(1'b0));
    chk("rst_rdata", 64'(m_rdata),  64'(32'h0));
    chk("rst_trap",  64'(trap_sel), 64'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Hit on window 0 with a slave that is already ready
    s_ready = 4'b0001;
    s_rdata[0*DATA_W +: DATA_W] = 32'hDEADBEEF;
    exp_q.push_back(mk(1'b0, 32'hDEADBEEF));
    issue(16'h0004);
    @(negedge clk);
    chk("t1_sel_c1",  64'(s_sel), 64'(4'b0001));
    chk("t1_busy_c1", 64'(busy),  64'(1'b1));
    chk("t1_noack_c1", 64'(m_ack), 64'(1'b0));
    @(negedge clk);
    chk("t1_ack_c2", 64'(m_ack), 64'(1'b1));
    chk("t1_sel_c2", 64'(s_sel), 64'(4'b0000));
    wait_idle("t1_idle");
    s_ready = '0;

    // Window 2 with a late ready; a ready pulse from slave 1 must be ignored
    s_rdata[2*DATA_W +: DATA_W] = 32'h0000_0005;
    s_rdata[1*DATA_W +: DATA_W] = 32'h0000_0BAD;
    exp_q.push_back(mk(1'b0, 32'h0000_0005));
    issue(16'h0812);
    s_ready[1] = 1'b1;
    @(negedge clk);
    chk("t2_sel_c1", 64'(s_sel), 64'(4'b0100));
    @(posedge clk);
    #1;
    s_ready[1] = 1'b0;
    @(negedge clk);
    chk("t2_sel_c2", 64'(s_sel), 64'(4'b0100));
    chk("t2_noack_c2", 64'(m_ack), 64'(1'b0));
    @(posedge clk);
    #1;
    s_ready[2] = 1'b1;
    @(negedge clk);
    chk("t2_sel_c3", 64'(s_sel), 64'(4'b0100));
    @(posedge clk);
    #1;
    s_ready[2] = 1'b0;
    @(negedge clk);
    chk("t2_ack_c4", 64'(m_ack), 64'(1'b1));
    chk("t2_sel_c4", 64'(s_sel), 64'(4'b0000));
    wait_idle("t2_idle");

    // Unmapped address: error ack in cycle 1, no slave selected
    exp_q.push_back(mk(1'b1, 32'h0));
    issue(16'h1000);
    @(negedge clk);
    chk("t3_ack_c1", 64'(m_ack), 64'(1'b1));
    chk("t3_sel_c1", 64'(s_sel), 64'(4'b0000));
    wait_idle("t3_idle");

    // Timeout on window 1: 15 WAIT cycles then error
    exp_q.push_back(mk(1'b1, 32'h0));
    issue(16'h0800);
    bad = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (s_sel !== 4'b0010 || m_ack !== 1'b0) bad++;
    end
    chk("t4_wait_window", 64'(bad), 64'(0));
    @(negedge clk);
    chk("t4_ack_timeout", 64'(m_ack), 64'(1'b1));
    chk("t4_sel_off",     64'(s_sel), 64'(4'b0000));
    wait_idle("t4_idle");

    // Ready in the last WAIT cycle beats the timeout
    s_rdata[1*DATA_W +: DATA_W] = 32'h1234_5678;
    exp_q.push_back(mk(1'b0, 32'h1234_5678));
    issue(16'h0800);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    s_ready[1] = 1'b1;
    @(negedge clk);
    chk("t5_sel_c15",   64'(s_sel), 64'(4'b0010));
    chk("t5_noack_c15", 64'(m_ack), 64'(1'b0));
    @(posedge clk);
    #1;
    s_ready[1] = 1'b0;
    @(negedge clk);
    chk("t5_ack_c16", 64'(m_ack), 64'(1'b1));
    wait_idle("t5_idle");

    // Requests during WAIT and during RESP are dropped
    ack_base = n_ack;
    s_rdata[3*DATA_W +: DATA_W] = 32'h0000_0033;
    exp_q.push_back(mk(1'b0, 32'h0000_0033));
    issue(16'h0814);
    m_req  = 1'b1;
    m_addr = 16'h0004;
    @(posedge clk);
    #1;
    m_req      = 1'b0;
    s_ready[3] = 1'b1;
    @(negedge clk);
    chk("t6_sel_c2",  64'(s_sel), 64'(4'b1000));
    chk("t6_busy_c2", 64'(busy),  64'(1'b1));
    @(posedge clk);
    #1;
    s_ready[3] = 1'b0;
    m_req      = 1'b1;
    m_addr     = 16'h0004;
    @(negedge clk);
    chk("t6_busy_resp", 64'(busy),  64'(1'b1));
    chk("t6_ack_c3",    64'(m_ack), 64'(1'b1));
    @(posedge clk);
    #1;
    m_req = 1'b0;
    @(negedge clk);
    chk("t6_idle_after_drop", 64'(busy), 64'(1'b0));
    repeat (25) @(negedge clk);
    chk("t6_single_ack", 64'(n_ack - ack_base), 64'(1));
    chk("t6_busy_end",   64'(busy),             64'(1'b0));

    // Asynchronous reset in the second WAIT cycle loses the transaction
    ack_base = n_ack;
    issue(16'h0800);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_sel",   64'(s_sel),   64'(4'b0000));
    chk("t7_rst_busy",  64'(busy),    64'(1'b0));
    chk("t7_rst_rdata", 64'(m_rdata), 64'(32'h0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t7_no_ack", 64'(n_ack - ack_base), 64'(0));
    s_ready = 4'b0001;
    s_rdata[0*DATA_W +: DATA_W] = 32'hCAFE_F00D;
    exp_q.push_back(mk(1'b0, 32'hCAFE_F00D));
    issue(16'h0004);
    @(negedge clk);
    chk("t7_fresh_sel", 64'(s_sel), 64'(4'b0001));
    @(negedge clk);
    chk("t7_fresh_ack", 64'(m_ack), 64'(1'b1));
    wait_idle("t7_idle");
    s_ready = '0;

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
